// File: rtl/multicycle_core.sv
// multicycle_core: FSM-sequenced RV64I/RV32I (or RV-E) core sharing one req/ready memory port.
// Optional macro PERF_COUNTERS_EN adds cycle_count/instret_count outputs.
//
// state | meaning
// IF    | fetch at pc, wait for mem_ready, latch IR
// ID    | decode, read operands, build immediate; illegal -> HALT
// EX    | ALU / beq compare / effective address; misaligned -> HALT
// MEM   | load/store on the memory port, wait for mem_ready
// WB    | register write, pc update, retire pulse
// HALT  | stopped until reset
module multicycle_core #(
  parameter int              XLEN     = 64,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            retire,
  output logic [XLEN-1:0] pc_out,
  output logic            halted,
  output logic            illegal_instr,
  output logic            misaligned
`ifdef PERF_COUNTERS_EN
  ,
  output logic [63:0]     cycle_count,
  output logic [63:0]     instret_count
`endif
);

  localparam int         RW      = $clog2(NREGS);
  localparam int         AW      = $clog2(XLEN / 8);
  localparam logic [2:0] LS_F3   = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_BEQ, OP_LD, OP_SD} op_t;

  state_t          state;
  op_t             op;
  logic [31:0]     ir;
  logic [XLEN-1:0] pc, rs1_val, rs2_val, imm, result;
  logic [RW-1:0]   rd;
  logic            br_taken;
  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic            dec_ok, use_rd, use_rs2;
  op_t             dec_op;
  logic [XLEN-1:0] dec_imm, imm_i, imm_s, imm_b, alu_out, pc_next;

  assign imm_i   = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s   = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b   = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign pc_next = br_taken ? pc + imm : pc + XLEN'(4);
  assign pc_out  = pc;

  always_comb begin
    opc     = ir[6:0];
    f3      = ir[14:12];
    f7      = ir[31:25];
    dec_ok  = 1'b1;
    dec_op  = OP_ADD;
    dec_imm = '0;
    use_rd  = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      7'b0110011: begin
        use_rd  = 1'b1;
        use_rs2 = 1'b1;
        if (f7 == 7'b0000000 && f3 == 3'b000)      dec_op = OP_ADD;
        else if (f7 == 7'b0100000 && f3 == 3'b000) dec_op = OP_SUB;
        else if (f7 == 7'b0000000 && f3 == 3'b111) dec_op = OP_AND;
        else if (f7 == 7'b0000000 && f3 == 3'b110) dec_op = OP_OR;
        else                                       dec_ok = 1'b0;
      end
      7'b0010011: begin
        use_rd  = 1'b1;
        dec_op  = OP_ADDI;
        dec_imm = imm_i;
        dec_ok  = (f3 == 3'b000);
      end
      7'b0000011: begin
        use_rd  = 1'b1;
        dec_op  = OP_LD;
        dec_imm = imm_i;
        dec_ok  = (f3 == LS_F3);
      end
      7'b0100011: begin
        use_rs2 = 1'b1;
        dec_op  = OP_SD;
        dec_imm = imm_s;
        dec_ok  = (f3 == LS_F3);
      end
      7'b1100011: begin
        use_rs2 = 1'b1;
        dec_op  = OP_BEQ;
        dec_imm = imm_b;
        dec_ok  = (f3 == 3'b000);
      end
      default: dec_ok = 1'b0;
    endcase
    // only fields the format actually uses are range-checked (matters for RV-E)
    if ({1'b0, ir[19:15]} >= NREGS_L)            dec_ok = 1'b0;
    if (use_rs2 && {1'b0, ir[24:20]} >= NREGS_L) dec_ok = 1'b0;
    if (use_rd && {1'b0, ir[11:7]} >= NREGS_L)   dec_ok = 1'b0;
  end

  always_comb begin
    alu_out = rs1_val + imm;
    case (op)
      OP_ADD:  alu_out = rs1_val + rs2_val;
      OP_SUB:  alu_out = rs1_val - rs2_val;
      OP_AND:  alu_out = rs1_val & rs2_val;
      OP_OR:   alu_out = rs1_val | rs2_val;
      default: alu_out = rs1_val + imm;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IF;
      op            <= OP_ADD;
      pc            <= RESET_PC;
      ir            <= '0;
      rs1_val       <= '0;
      rs2_val       <= '0;
      imm           <= '0;
      result        <= '0;
      rd            <= '0;
      br_taken      <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      retire        <= 1'b0;
      halted        <= 1'b0;
      illegal_instr <= 1'b0;
      misaligned    <= 1'b0;
    end else begin
      case (state)
        S_IF: begin
          // first fetch after reset raises the request here; later fetches are launched from WB
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end else if (mem_ready) begin
            ir      <= mem_rdata[31:0];
            mem_req <= 1'b0;
            state   <= S_ID;
          end
        end
        S_ID: begin
          if (!dec_ok) begin
            halted        <= 1'b1;
            illegal_instr <= 1'b1;
            state         <= S_HALT;
          end else begin
            op      <= dec_op;
            imm     <= dec_imm;
            rs1_val <= regs[ir[15 +: RW]];
            rs2_val <= regs[ir[20 +: RW]];
            rd      <= ir[7 +: RW];
            state   <= S_EX;
          end
        end
        S_EX: begin
          result   <= alu_out;
          br_taken <= (op == OP_BEQ) && (rs1_val == rs2_val);
          if (op == OP_LD || op == OP_SD) begin
            if (alu_out[AW-1:0] != '0) begin
              halted     <= 1'b1;
              misaligned <= 1'b1;
              state      <= S_HALT;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= (op == OP_SD);
              mem_addr  <= alu_out;
              mem_wdata <= rs2_val;
              state     <= S_MEM;
            end
          end else begin
            retire <= 1'b1;
            state  <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op == OP_LD) result <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            retire  <= 1'b1;
            state   <= S_WB;
          end
        end
        S_WB: begin
          if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD} && rd != '0)
            regs[rd] <= result;
          pc       <= pc_next;
          mem_addr <= pc_next;
          mem_req  <= 1'b1;
          retire   <= 1'b0;
          state    <= S_IF;
        end
        default: state <= S_HALT;
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (state != S_HALT) cycle_count <= cycle_count + 64'd1;
      if (retire)          instret_count <= instret_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed and random programs for multicycle_core, checked against an
// instruction-level reference model; the bench also plays the memory with random wait states.
`timescale 1ns/1ps
module tb_multicycle_core;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, retire, halted, illegal_instr, misaligned;
  logic        mem_ready = 1'b0;
  logic [63:0] mem_addr, mem_wdata, pc_out;
  logic [63:0] mem_rdata = '0;
`ifdef PERF_COUNTERS_EN
  logic [63:0] cycle_count, instret_count;
`endif

  multicycle_core #(.XLEN(64), .NREGS(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .pc_out(pc_out), .halted(halted),
    .illegal_instr(illegal_instr), .misaligned(misaligned)
`ifdef PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bench memory (what the core talks to) and reference-model state
  logic [31:0] imem [64];
  logic [63:0] dmem [64];
  logic [63:0] m_dmem [64];
  logic [63:0] mr [32];
  logic [63:0] m_pc;

  int          ready_pct = 100;
  int          stall_on_fetch = -1;
  int          stall_left = 0;
  int          hold_cnt = 0;
  bit          expect_fetch = 1'b1;
  bit          pend = 1'b0;
  bit          prev_retire = 1'b0;
  logic [63:0] p_addr, p_wdata;
  logic        p_we;
  int          retire_cyc[$];
  logic [63:0] fetch_q[$];
  int          hold_q[$];
  logic [63:0] st_addr_q[$];
  logic [63:0] st_data_q[$];

  function automatic logic [63:0] sx12(input logic [11:0] v);
    return {{52{v[11]}}, v};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input int rd, input int rs1,
                                        input logic [2:0] f3, input logic [11:0] imm);
    return {imm, 5'(rs1), f3, 5'(rd), opc};
  endfunction

  function automatic logic [31:0] enc_s(input int rs2, input int rs1, input logic [11:0] imm);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'b011, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int rs1, input int rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic bit is_legal(input logic [31:0] w);
    case (w[6:0])
      7'h33:        return (w[31:25] == 7'h00 && (w[14:12] == 3'd0 || w[14:12] == 3'd7 || w[14:12] == 3'd6))
                        || (w[31:25] == 7'h20 && w[14:12] == 3'd0);
      7'h13, 7'h63: return w[14:12] == 3'd0;
      7'h03, 7'h23: return w[14:12] == 3'd3;
      default:      return 1'b0;
    endcase
  endfunction

  // executes the instruction at m_pc architecturally
  task automatic model_step();
    logic [31:0] w;
    logic [63:0] a, b, val, ea, npc;
    bit          wr;
    w   = imem[m_pc[7:2]];
    a   = mr[w[19:15]];
    b   = mr[w[24:20]];
    val = '0;
    wr  = 1'b0;
    npc = m_pc + 64'd4;
    case (w[6:0])
      7'h33: begin
        wr = 1'b1;
        if (w[30])                  val = a - b;
        else if (w[14:12] == 3'd7)  val = a & b;
        else if (w[14:12] == 3'd6)  val = a | b;
        else                        val = a + b;
      end
      7'h13: begin wr = 1'b1; val = a + sx12(w[31:20]); end
      7'h03: begin wr = 1'b1; ea = a + sx12(w[31:20]); val = m_dmem[ea[8:3]]; end
      7'h23: begin ea = a + sx12({w[31:25], w[11:7]}); m_dmem[ea[8:3]] = b; end
      7'h63: if (a == b) npc = m_pc + {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: ;
    endcase
    if (wr && w[11:7] != 5'd0) mr[w[11:7]] = val;
    m_pc = npc;
  endtask

  task automatic serve();
    logic [31:0] w;
    logic [63:0] ea;
    if (expect_fetch) begin
      check_eq("fetch_addr", mem_addr, m_pc);
      check_eq("fetch_we", 64'(mem_we), 64'd0);
      mem_rdata = {$urandom(), imem[mem_addr[7:2]]};
      fetch_q.push_back(mem_addr);
      hold_q.push_back(hold_cnt);
      hold_cnt = 0;
      expect_fetch = 1'b0;
    end else begin
      w = imem[m_pc[7:2]];
      if (mem_we) begin
        ea = mr[w[19:15]] + sx12({w[31:25], w[11:7]});
        check_eq("store_addr", mem_addr, ea);
        check_eq("store_data", mem_wdata, mr[w[24:20]]);
        dmem[mem_addr[8:3]] = mem_wdata;
        st_addr_q.push_back(mem_addr);
        st_data_q.push_back(mem_wdata);
      end else begin
        ea = mr[w[19:15]] + sx12(w[31:20]);
        check_eq("load_addr", mem_addr, ea);
        mem_rdata = dmem[mem_addr[8:3]];
      end
    end
  endtask

  // memory responder and retire monitor
  always @(negedge clk) begin
    if (!rst) begin
      mem_ready   = 1'b0;
      pend        = 1'b0;
      prev_retire = 1'b0;
    end else begin
      if (retire) begin
        check_eq("retire_pulse", 64'(prev_retire), 64'd0);
        check_eq("retire_pc", pc_out, m_pc);
        retire_cyc.push_back(cyc);
        model_step();
        expect_fetch = 1'b1;
      end
      prev_retire = retire;
      if (pend) begin
        check_eq("req_hold", 64'(mem_req), 64'd1);
        check_eq("addr_hold", mem_addr, p_addr);
        check_eq("we_hold", 64'(mem_we), 64'(p_we));
        check_eq("wdata_hold", mem_wdata, p_wdata);
      end
      if (mem_req) begin
        if (expect_fetch && !pend && fetch_q.size() == stall_on_fetch) stall_left = 3;
        if (expect_fetch) hold_cnt++;
        if (stall_left > 0) begin
          stall_left--;
          mem_ready = 1'b0;
        end else begin
          mem_ready = ($urandom_range(0, 99) < ready_pct);
        end
        if (mem_ready) serve();
      end else begin
        // stray ready without a request must be ignored
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = {$urandom(), $urandom()};
      end
      pend    = mem_req && !mem_ready;
      p_addr  = mem_addr;
      p_we    = mem_we;
      p_wdata = mem_wdata;
    end
  end

  task automatic init_model();
    m_pc = 64'h0;
    for (int i = 0; i < 32; i++) mr[i] = '0;
    for (int i = 0; i < 64; i++) m_dmem[i] = dmem[i];
    expect_fetch   = 1'b1;
    stall_left     = 0;
    stall_on_fetch = -1;
    hold_cnt       = 0;
    retire_cyc.delete();
    fetch_q.delete();
    hold_q.delete();
    st_addr_q.delete();
    st_data_q.delete();
  endtask

  task automatic reset_core(input bit now);
    if (now) #1;
    else begin
      @(posedge clk);
      #2;
    end
    rst = 1'b0;
    #1;
    check_eq("rst_flags", 64'({mem_req, mem_we, retire, halted, illegal_instr, misaligned}), 64'd0);
    check_eq("rst_pc", pc_out, 64'h0);
    check_eq("rst_addr", mem_addr, 64'h0);
    check_eq("rst_wdata", mem_wdata, 64'h0);
`ifdef PERF_COUNTERS_EN
    check_eq("rst_cycle_count", cycle_count, 64'd0);
    check_eq("rst_instret_count", instret_count, 64'd0);
`endif
    init_model();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_retires(input int n, input string tag);
    int k = 0;
    while (retire_cyc.size() < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check_eq({tag, "_retired"}, 64'(retire_cyc.size() >= n), 64'd1);
  endtask

  task automatic wait_halt(input string tag);
    int k = 0;
    while (!halted && k < 5000) begin
      @(posedge clk);
      k++;
    end
    #1 check_eq({tag, "_halted"}, 64'(halted), 64'd1);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic load_prog_a();
    clear_imem();
    imem[0] = enc_i(7'h13, 1, 0, 3'b000, 12'd5);        // addi x1,x0,5
    imem[1] = enc_r(7'h00, 1, 1, 3'b000, 2);            // add  x2,x1,x1
    imem[2] = enc_s(2, 0, 12'd8);                       // sd   x2,8(x0)
    imem[3] = enc_i(7'h03, 3, 0, 3'b011, 12'd8);        // ld   x3,8(x0)
    imem[4] = enc_b(1, 0, 13'd8);                       // beq  x1,x0,+8 (not taken)
    imem[5] = enc_s(3, 0, 12'd16);                      // sd   x3,16(x0)
    imem[6] = enc_b(1, 1, 13'h1FF8);                    // beq  x1,x1,-8 -> 0x10
  endtask

  task automatic gen_random(input int n);
    int kind, rd, rs1, rs2;
    clear_imem();
    for (int i = 0; i < 64; i++) dmem[i] = {$urandom(), $urandom()};
    for (int i = 1; i < 8; i++) imem[i-1] = enc_i(7'h13, i, 0, 3'b000, 12'($urandom_range(0, 4095)));
    for (int i = 7; i < n; i++) begin
      kind = $urandom_range(0, 7);
      rd   = $urandom_range(0, 7);
      rs1  = $urandom_range(0, 7);
      rs2  = $urandom_range(0, 7);
      case (kind)
        0: imem[i] = enc_r(7'h00, rs2, rs1, 3'b000, rd);
        1: imem[i] = enc_r(7'h20, rs2, rs1, 3'b000, rd);
        2: imem[i] = enc_r(7'h00, rs2, rs1, 3'b111, rd);
        3: imem[i] = enc_r(7'h00, rs2, rs1, 3'b110, rd);
        4: imem[i] = enc_i(7'h13, rd, rs1, 3'b000, 12'($urandom_range(0, 4095)));
        5: imem[i] = enc_s(rs2, 0, 12'(8 * $urandom_range(0, 15)));
        6: imem[i] = enc_i(7'h03, rd, 0, 3'b011, 12'(8 * $urandom_range(0, 15)));
        default: imem[i] = enc_b(rs1, ($urandom_range(0, 1) == 1) ? rs1 : rs2, 13'd8);
      endcase
    end
    imem[n] = 32'hFFFFFFFF;
  endtask

  int exp_lat [6] = '{4, 5, 5, 4, 5, 4};
  bit found;

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = '0;

    // straight-line ALU, store/load pair, both beq directions, zero-wait memory
    ready_pct = 100;
    load_prog_a();
    reset_core(1'b0);
    wait_retires(7, "prog_a");
    if (retire_cyc.size() >= 7)
      for (int i = 1; i < 7; i++) check_eq("latency", 64'(retire_cyc[i] - retire_cyc[i-1]), 64'(exp_lat[i-1]));
    if (st_data_q.size() >= 2) begin
      check_eq("sd_x2_addr", st_addr_q[0], 64'd8);
      check_eq("sd_x2_data", st_data_q[0], 64'd10);
      check_eq("sd_x3_data", st_data_q[1], 64'd10);
    end
    if (fetch_q.size() >= 8) begin
      check_eq("beq_untaken_fetch", fetch_q[5], 64'h14);
      check_eq("beq_taken_fetch", fetch_q[7], 64'h10);
    end

    // reset while a store request is outstanding
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk);
      #1;
      if (mem_req && mem_we) found = 1'b1;
    end
    check_eq("mid_mem_found", 64'(found), 64'd1);
    reset_core(1'b1);
    wait_retires(1, "after_reset");
    if (fetch_q.size() >= 1) check_eq("refetch_addr", fetch_q[0], 64'h0);

    // three wait states on the second fetch
    reset_core(1'b0);
    stall_on_fetch = 1;
    wait_retires(2, "stall");
    if (retire_cyc.size() >= 2) check_eq("stall_latency", 64'(retire_cyc[1] - retire_cyc[0]), 64'd7);
    if (hold_q.size() >= 2) check_eq("stall_hold", 64'(hold_q[1]), 64'd4);

    // illegal encoding halts with no request
    clear_imem();
    imem[0] = 32'hFFFFFFFF;
    reset_core(1'b0);
    wait_halt("illegal");
    check_eq("illegal_flag", 64'({illegal_instr, misaligned}), 64'b10);
    check_eq("illegal_retired", 64'(retire_cyc.size()), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 check_eq("illegal_req_low", 64'({mem_req, halted}), 64'b01);
    end

    // doubleword load from address 4
    clear_imem();
    imem[0] = enc_i(7'h13, 1, 0, 3'b000, 12'd4);
    imem[1] = enc_i(7'h03, 2, 1, 3'b011, 12'd0);
    reset_core(1'b0);
    wait_halt("misaligned");
    check_eq("misaligned_flag", 64'({illegal_instr, misaligned}), 64'b01);
    check_eq("misaligned_retired", 64'(retire_cyc.size()), 64'd1);
    @(posedge clk);
    #1 check_eq("misaligned_req_low", 64'(mem_req), 64'd0);

    // random programs with random wait states
    for (int r = 0; r < 4; r++) begin
      ready_pct = 40 + 15 * r;
      gen_random(44);
      reset_core(1'b0);
      wait_halt("random");
      check_eq("random_illegal", 64'({illegal_instr, misaligned}), 64'b10);
      check_eq("random_halt_at_illegal", 64'(is_legal(imem[m_pc[7:2]])), 64'd0);
`ifdef PERF_COUNTERS_EN
      check_eq("random_instret", instret_count, 64'(retire_cyc.size()));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
